// File: rtl/l3fwd_actn_exec.sv
// L3 forwarding action executor: applies the beat-0 action (drop / MAC+TTL+checksum
// rewrite / pass), strips the action from tuser and counts forwarded and dropped frames.
module l3fwd_actn_exec #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4,
  parameter int ACTN_WIDTH = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH+ACTN_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  input  logic                             cnt_clr,
  output logic [31:0]                      cnt_fwd,
  output logic [31:0]                      cnt_drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] m_tdata_reg;
  logic [KEEP_WIDTH-1:0] m_tkeep_reg;
  logic                  m_tvalid_reg;
  logic                  m_tlast_reg;
  logic [ID_WIDTH-1:0]   m_tid_reg;
  logic [DEST_WIDTH-1:0] m_tdest_reg;
  logic [USER_WIDTH-1:0] m_tuser_reg;
  logic [DEST_WIDTH-1:0] frame_dest_reg;
  logic [31:0]           cnt_fwd_reg, cnt_drop_reg;

  logic [ACTN_WIDTH-1:0] actn;
  logic                  unused_actn;
  assign actn        = s_axis_tuser[USER_WIDTH +: ACTN_WIDTH];
  assign unused_actn = ^actn;

  // Beat-0 classification, evaluated on whatever is presented while idle
  logic       is_runt, is_ipv4, ttl_low, beat0_drop, beat0_rewrite;
  logic [7:0] ttl;
  assign ttl           = s_axis_tdata[8*22 +: 8];
  assign is_runt       = ~&s_axis_tkeep[25:0];
  assign is_ipv4       = (s_axis_tdata[8*12 +: 8] == 8'h08) && (s_axis_tdata[8*13 +: 8] == 8'h00);
  assign ttl_low       = (ttl <= 8'd1);
  assign beat0_drop    = is_runt || !actn[127] || actn[126] || (is_ipv4 && ttl_low);
  assign beat0_rewrite = !beat0_drop && is_ipv4;

  logic [95:0] mac_bytes;
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mac
      assign mac_bytes[8*gi +: 8]     = actn[119-8*gi -: 8];
      assign mac_bytes[8*(gi+6) +: 8] = actn[71-8*gi -: 8];
    end
  endgenerate

  // TTL drop lowers the {ttl,proto} word by 0x0100, so the complemented sum rises by 0x0100
  logic [15:0] hc_old, hc_new;
  logic [16:0] hc_sum;
  assign hc_old = {s_axis_tdata[8*24 +: 8], s_axis_tdata[8*25 +: 8]};
  assign hc_sum = {1'b0, hc_old} + 17'h00100;
  assign hc_new = hc_sum[15:0] + {15'd0, hc_sum[16]};

  logic [DATA_WIDTH-1:0] rw_data;
  always_comb begin
    rw_data                 = s_axis_tdata;
    rw_data[95:0]           = mac_bytes;
    rw_data[8*22 +: 8]      = ttl - 8'd1;
    rw_data[8*24 +: 8]      = hc_new[15:8];
    rw_data[8*25 +: 8]      = hc_new[7:0];
  end

  logic                  out_ready, in_first, in_xfer, fwd_beat, drop_first;
  logic [DEST_WIDTH-1:0] beat0_dest, out_dest;
  logic [DATA_WIDTH-1:0] out_data;

  assign out_ready     = m_axis_tready || !m_tvalid_reg;
  assign s_axis_tready = rst && ((state_reg == ST_DROP) || out_ready);
  assign in_first      = (state_reg == ST_IDLE);
  assign in_xfer       = s_axis_tvalid && s_axis_tready;
  assign fwd_beat      = in_xfer && ((in_first && !beat0_drop) || (state_reg == ST_PASS));
  assign drop_first    = in_xfer && in_first && beat0_drop;
  assign beat0_dest    = beat0_rewrite ? actn[120 +: DEST_WIDTH] : s_axis_tdest;
  assign out_dest      = in_first ? beat0_dest : frame_dest_reg;
  assign out_data      = (in_first && beat0_rewrite) ? rw_data : s_axis_tdata;

  always_comb begin
    state_next = state_reg;
    if (in_xfer) begin
      if (s_axis_tlast)
        state_next = ST_IDLE;
      else if (in_first)
        state_next = beat0_drop ? ST_DROP : ST_PASS;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      m_tdata_reg    <= '0;
      m_tkeep_reg    <= '0;
      m_tvalid_reg   <= 1'b0;
      m_tlast_reg    <= 1'b0;
      m_tid_reg      <= '0;
      m_tdest_reg    <= '0;
      m_tuser_reg    <= '0;
      frame_dest_reg <= '0;
      cnt_fwd_reg    <= '0;
      cnt_drop_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (in_xfer && in_first)
        frame_dest_reg <= beat0_dest;
      if (fwd_beat) begin
        m_tdata_reg  <= out_data;
        m_tkeep_reg  <= s_axis_tkeep;
        m_tvalid_reg <= 1'b1;
        m_tlast_reg  <= s_axis_tlast;
        m_tid_reg    <= s_axis_tid;
        m_tdest_reg  <= out_dest;
        m_tuser_reg  <= s_axis_tuser[USER_WIDTH-1:0];
      end else if (m_axis_tready) begin
        m_tvalid_reg <= 1'b0;
      end
      if (cnt_clr)
        cnt_drop_reg <= '0;
      else if (drop_first)
        cnt_drop_reg <= cnt_drop_reg + 32'd1;
      if (cnt_clr)
        cnt_fwd_reg <= '0;
      else if (m_tvalid_reg && m_axis_tready && m_tlast_reg)
        cnt_fwd_reg <= cnt_fwd_reg + 32'd1;
    end
  end

  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tkeep  = m_tkeep_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tlast  = m_tlast_reg;
  assign m_axis_tid    = m_tid_reg;
  assign m_axis_tdest  = m_tdest_reg;
  assign m_axis_tuser  = m_tuser_reg;
  assign cnt_fwd       = cnt_fwd_reg;
  assign cnt_drop      = cnt_drop_reg;

endmodule

// File: tb/tb_l3fwd_actn_exec.sv
// Bench for l3fwd_actn_exec: directed action cases plus randomized frames under
// backpressure, checked against a frame-level reference model and scoreboard.
module tb_l3fwd_actn_exec;
  localparam int DW = 512, KW = 64, IW = 8, DSW = 4, UW = 4, AW = 128;

  typedef struct {
    logic [DW-1:0]    data;
    logic [KW-1:0]    keep;
    logic             last;
    logic [IW-1:0]    id;
    logic [DSW-1:0]   dest;
    logic [UW+AW-1:0] user;
  } in_beat_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } out_beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0]    s_axis_tdata;
  logic [KW-1:0]    s_axis_tkeep;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [IW-1:0]    s_axis_tid;
  logic [DSW-1:0]   s_axis_tdest;
  logic [UW+AW-1:0] s_axis_tuser;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;
  logic [DSW-1:0]   m_axis_tdest;
  logic [UW-1:0]    m_axis_tuser;
  logic             cnt_clr;
  logic [31:0]      cnt_fwd, cnt_drop;

  l3fwd_actn_exec dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .cnt_clr(cnt_clr), .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          frame_no = 0;
  int          bp_mode = 0;
  logic [31:0] exp_fwd = 0, exp_drop = 0;
  in_beat_t    frame_q[$];
  out_beat_t   exp_q[$];
  logic [DW-1:0]  first_data;
  logic [DSW-1:0] first_dest;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic build_frame(input int nb, input bit hit, input bit drp, input logic [15:0] et,
                             input logic [7:0] ttl, input logic [15:0] hc, input logic [3:0] port,
                             input logic [47:0] dmac, input logic [47:0] smac, input bit runt);
    in_beat_t b;
    logic [127:0] a;
    frame_q.delete();
    for (int i = 0; i < nb; i++) begin
      b.data = rand_data();
      b.keep = '1;
      b.last = (i == nb-1);
      b.id   = 8'($urandom);
      b.dest = 4'($urandom);
      a = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) begin
        a[127] = hit; a[126] = drp; a[123:120] = port; a[119:72] = dmac; a[71:24] = smac;
        b.data[8*12 +: 8] = et[15:8];
        b.data[8*13 +: 8] = et[7:0];
        b.data[8*22 +: 8] = ttl;
        b.data[8*24 +: 8] = hc[15:8];
        b.data[8*25 +: 8] = hc[7:0];
        if (runt) b.keep = 64'h0000_0000_0000_FFFF;
      end else if (b.last) begin
        b.keep = {$urandom, $urandom};
      end
      b.user = {a, 4'($urandom)};
      frame_q.push_back(b);
    end
  endtask

  // Reference: classify the frame from its first beat, then emit expected beats
  task automatic model_frame();
    in_beat_t  b0;
    out_beat_t o;
    logic [127:0] a;
    logic [47:0]  dmac, smac;
    logic [15:0]  et, hc;
    logic [7:0]   ttl;
    int  s;
    bit  drop_it, rewrite;
    b0 = frame_q[0];
    a = b0.user[UW +: AW];
    dmac = a[119:72];
    smac = a[71:24];
    et = {b0.data[8*12 +: 8], b0.data[8*13 +: 8]};
    ttl = b0.data[8*22 +: 8];
    hc = {b0.data[8*24 +: 8], b0.data[8*25 +: 8]};
    drop_it = 0;
    rewrite = 0;
    if ($countones(b0.keep[25:0]) != 26) drop_it = 1;
    else if (!a[127] || a[126]) drop_it = 1;
    else if (et != 16'h0800) rewrite = 0;
    else if (ttl < 2) drop_it = 1;
    else rewrite = 1;
    if (drop_it) begin
      exp_drop++;
      return;
    end
    foreach (frame_q[i]) begin
      o.data = frame_q[i].data;
      o.keep = frame_q[i].keep;
      o.last = frame_q[i].last;
      o.id   = frame_q[i].id;
      o.dest = rewrite ? a[123:120] : b0.dest;
      o.user = frame_q[i].user[UW-1:0];
      if (i == 0 && rewrite) begin
        for (int k = 0; k < 6; k++) begin
          o.data[8*k +: 8]     = 8'(dmac >> (40 - 8*k));
          o.data[8*(k+6) +: 8] = 8'(smac >> (40 - 8*k));
        end
        o.data[8*22 +: 8] = ttl - 8'd1;
        s = int'(hc) + 256;
        if (s > 65535) s = s - 65536 + 1;
        o.data[8*24 +: 8] = 8'(s >> 8);
        o.data[8*25 +: 8] = 8'(s);
      end
      exp_q.push_back(o);
    end
    exp_fwd++;
  endtask

  task automatic drive_beat(input in_beat_t b);
    bit ok = 0;
    s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tlast = b.last;
    s_axis_tid = b.id; s_axis_tdest = b.dest; s_axis_tuser = b.user;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (s_axis_tready) begin ok = 1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    s_axis_tvalid = 1'b0;
    check_eq("accept", ok, 1);
  endtask

  task automatic send_beats(input int limit);
    for (int i = 0; i < limit; i++) begin
      drive_beat(frame_q[i]);
      if (bp_mode == 1 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input string tag);
    frame_no++;
    $display("frame %0d %s beats %0d", frame_no, tag, frame_q.size());
    model_frame();
    send_beats(frame_q.size());
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_axis_tvalid) begin done = 1; break; end
    end
    check_eq("drain", done, 1);
  endtask

  task automatic check_counters();
    check_eq("cnt_fwd", cnt_fwd, exp_fwd);
    check_eq("cnt_drop", cnt_drop, exp_drop);
  endtask

  task automatic set_bp(input int mode);
    bp_mode = mode;
    @(posedge clk); #2;
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare on every transfer, hold check while stalled
  initial begin
    out_beat_t e;
    bit in_frame = 0, stall_prev = 0;
    logic [DW-1:0]  hold_data;
    logic [127:0]   hold_ctl;
    forever begin
      @(negedge clk);
      if (stall_prev && rst) begin
        check_eq("stall_valid", m_axis_tvalid, 1);
        check_eq("stall_data", m_axis_tdata, hold_data);
        check_eq("stall_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser}, hold_ctl);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", m_axis_tdata, e.data);
          check_eq("out_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser},
                   {e.keep, e.last, e.id, e.dest, e.user});
        end
        if (!in_frame) begin
          first_data = m_axis_tdata;
          first_dest = m_axis_tdest;
        end
        in_frame = !m_axis_tlast;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_data  = m_axis_tdata;
      hold_ctl   = 128'({m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser});
      if (!rst) begin in_frame = 0; stall_prev = 0; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DSW-1:0] orig_dest;
    logic [DW-1:0]  orig_data;
    int k, nb;
    logic [15:0] et;
    rst = 1'b0; cnt_clr = 1'b0; s_axis_tvalid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_counters();
    @(posedge clk); #1;
    rst = 1'b1;

    build_frame(2, 1, 0, 16'h0800, 8'd64, 16'hB1E6, 4'd3, 48'h020000000001, 48'h020000000002, 0);
    run_frame("fwd");
    wait_drain();
    check_eq("fwd_dmac", first_data[47:0], 48'h010000000002);
    check_eq("fwd_smac", first_data[95:48], 48'h020000000002);
    check_eq("fwd_ttl", first_data[8*22 +: 8], 8'd63);
    check_eq("fwd_hc", {first_data[8*24 +: 8], first_data[8*25 +: 8]}, 16'hB2E6);
    check_eq("fwd_dest", first_dest, 4'd3);
    check_eq("fwd_count", cnt_fwd, 32'd1);

    build_frame(1, 1, 0, 16'h0800, 8'd10, 16'hFF80, 4'd1, 48'h0a0b0c0d0e0f, 48'h111213141516, 0);
    run_frame("carry");
    wait_drain();
    check_eq("carry_hc", {first_data[8*24 +: 8], first_data[8*25 +: 8]}, 16'h0081);
    check_eq("carry_ttl", first_data[8*22 +: 8], 8'd9);
    build_frame(3, 1, 0, 16'h0800, 8'd2, 16'h1234, 4'd2, 48'h1, 48'h2, 0);
    run_frame("ttl2");
    wait_drain();
    check_eq("ttl2_ttl", first_data[8*22 +: 8], 8'd1);
    check_counters();

    set_bp(2);
    build_frame(3, 0, 0, 16'h0800, 8'd64, 16'h0, 4'd3, 48'h1, 48'h2, 0);
    run_frame("miss_stalled");
    wait_drain();
    check_counters();
    set_bp(0);
    build_frame(2, 1, 1, 16'h0800, 8'd64, 16'h0, 4'd3, 48'h1, 48'h2, 0);
    run_frame("drop_flag");
    wait_drain();
    check_counters();
    build_frame(2, 1, 0, 16'h0800, 8'd1, 16'h0, 4'd3, 48'h1, 48'h2, 0);
    run_frame("ttl1");
    build_frame(1, 1, 0, 16'h0800, 8'd0, 16'h0, 4'd3, 48'h1, 48'h2, 0);
    run_frame("ttl0");
    build_frame(1, 1, 0, 16'h0800, 8'd64, 16'h0, 4'd3, 48'h1, 48'h2, 1);
    run_frame("runt");
    wait_drain();
    check_counters();

    build_frame(2, 1, 0, 16'h86DD, 8'd64, 16'hBEEF, 4'd5, 48'h1, 48'h2, 0);
    orig_dest = frame_q[0].dest;
    orig_data = frame_q[0].data;
    run_frame("non_ipv4");
    wait_drain();
    check_eq("nonip_dest", first_dest, orig_dest);
    check_eq("nonip_data", first_data, orig_data);
    check_counters();

    set_bp(1);
    for (int f = 0; f < 100; f++) begin
      k = $urandom_range(0, 9);
      nb = $urandom_range(1, 4);
      et = 16'($urandom);
      if (et == 16'h0800) et = 16'h86DD;
      case (k)
        0: build_frame(nb, 0, 0, 16'h0800, 8'd64, 16'($urandom), 4'($urandom), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 0);
        1: build_frame(nb, 1, 1, 16'h0800, 8'd64, 16'($urandom), 4'($urandom), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 0);
        2: build_frame(nb, 1, 0, 16'h0800, 8'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 0);
        3: build_frame(nb, 1, 0, et, 8'($urandom), 16'($urandom), 4'($urandom), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 0);
        4: build_frame(nb, 1, 0, 16'h0800, 8'd64, 16'($urandom), 4'($urandom), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 1);
        default: build_frame(nb, 1, 0, 16'h0800, 8'($urandom_range(2, 255)), 16'($urandom), 4'($urandom), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 0);
      endcase
      run_frame("random");
    end
    wait_drain();
    check_counters();

    // Reset mid-frame: two beats of a three-beat frame, then reset
    set_bp(0);
    build_frame(3, 1, 0, 16'h0800, 8'd40, 16'h4321, 4'd6, 48'h1, 48'h2, 0);
    frame_no++;
    $display("frame %0d reset_mid beats 2", frame_no);
    model_frame();
    void'(exp_q.pop_back());
    send_beats(2);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    check_eq("midrst_tvalid", m_axis_tvalid, 0);
    check_eq("midrst_flush", exp_q.size(), 0);
    exp_fwd = 0;
    exp_drop = 0;
    check_counters();
    rst = 1'b1;
    build_frame(2, 1, 0, 16'h0800, 8'd33, 16'hA5A5, 4'd7, 48'h3, 48'h4, 0);
    run_frame("after_reset");
    wait_drain();
    check_counters();

    build_frame(1, 1, 0, 16'h0800, 8'd33, 16'hA5A5, 4'd7, 48'h3, 48'h4, 0);
    run_frame("clr_collide");
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_fwd = 0;
    exp_drop = 0;
    wait_drain();
    check_eq("clr_fwd", cnt_fwd, 32'd0);
    check_counters();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
